pipelined_barrel_shifter: RTL and testbench

- Parametrised, fully pipelined barrel shifter for the datapath lab series.
- Generalises the fixed 16-bit combinational left shifter to:
  - any power-of-two WIDTH;
  - four shift modes;
  - one register stage per log2 shift level;
  - valid/ready handshake with back-pressure.
- Sits between the operand register file and the ALU result mux. One new operation per cycle; fixed latency.

---
 rtl/pipelined_barrel_shifter.sv | 117 +++++++++++
 tb/tb_pipelined_barrel_shifter.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_barrel_shifter.sv
// Fully pipelined barrel shifter: one register stage per shift level (2^k per stage),
// LSL/LSR/ASR/ROL modes, valid/ready handshake with a global stall on output back-pressure.
module pipelined_barrel_shifter #(
  parameter  int WIDTH = 16,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shamt,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_mode,
  output logic             out_zero
);

  typedef enum logic [1:0] {
    MODE_LSL = 2'd0,
    MODE_LSR = 2'd1,
    MODE_ASR = 2'd2,
    MODE_ROL = 2'd3
  } mode_e;

  if ((WIDTH < 4) || (WIDTH > 64) || ((WIDTH & (WIDTH - 1)) != 0)) begin : g_bad_width
    $error("pipelined_barrel_shifter: WIDTH must be a power of two in 4..64");
  end

  // One fixed-distance step; right modes are native shifts, not mirrored left shifts.
  function automatic logic [WIDTH-1:0] shift_step(input logic [WIDTH-1:0] d,
                                                  input logic [1:0]       mode,
                                                  input int               amt);
    logic [WIDTH-1:0] r;
    // NOTE: every path assigns r, so no storage is implied in combinational use.
    case (mode_e'(mode))
      MODE_LSL: r = d << amt;
      MODE_LSR: r = d >> amt;
      MODE_ASR: r = $unsigned($signed(d) >>> amt);
      default:  r = (d << amt) | (d >> (WIDTH - amt));
    endcase
    return r;
  endfunction

  // Stage inputs (src_*), stage results (step_data) and stage registers (st_*).
  logic             src_valid [SHW];
  logic [WIDTH-1:0] src_data  [SHW];
  logic [1:0]       src_mode  [SHW];
  logic [SHW-1:0]   src_shamt [SHW];
  logic [WIDTH-1:0] step_data [SHW];

  logic             st_valid  [SHW];
  logic [WIDTH-1:0] st_data   [SHW];
  logic [1:0]       st_mode   [SHW];
  logic [SHW-1:0]   st_shamt  [SHW];
  logic             zero_q;

  logic advance;

  // The whole pipeline freezes while a finished result waits for the consumer.
  assign in_ready = !(out_valid && !out_ready);
  assign advance  = in_ready;

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign src_valid[k] = in_valid;
      assign src_data[k]  = in_data;
      assign src_mode[k]  = in_mode;
      assign src_shamt[k] = in_shamt;
    end else begin : g_body
      assign src_valid[k] = st_valid[k-1];
      assign src_data[k]  = st_data[k-1];
      assign src_mode[k]  = st_mode[k-1];
      assign src_shamt[k] = st_shamt[k-1];
    end

    assign step_data[k] = src_shamt[k][k] ? shift_step(src_data[k], src_mode[k], 1 << k)
                                          : src_data[k];
  end

  // NOTE: state uses non-blocking assignments so every stage samples its
  // predecessor's pre-edge value, which is what makes this a pipeline.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the stage registers are few and feed out_* directly, so all of
      // them are reset, not just the valid bits.
      for (int k = 0; k < SHW; k++) begin
        st_valid[k] <= 1'b0;
        st_data[k]  <= '0;
        st_mode[k]  <= '0;
        st_shamt[k] <= '0;
      end
      zero_q <= 1'b0;
    end else if (advance) begin
      for (int k = 0; k < SHW; k++) begin
        st_valid[k] <= src_valid[k];
        // Payload only moves with a valid operation, so bubbles leave out_* untouched.
        if (src_valid[k]) begin
          st_data[k]  <= step_data[k];
          st_mode[k]  <= src_mode[k];
          st_shamt[k] <= src_shamt[k];
        end
      end
      if (src_valid[SHW-1]) begin
        zero_q <= (step_data[SHW-1] == '0);
      end
    end
  end

  assign out_valid = st_valid[SHW-1];
  assign out_data  = st_data[SHW-1];
  assign out_mode  = st_mode[SHW-1];
  assign out_zero  = zero_q;

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Bench for pipelined_barrel_shifter: a 16-bit and a 32-bit instance, an arithmetic
// reference model with an in-order scoreboard, and directed vectors with literal results.
module tb_pipelined_barrel_shifter;

  localparam logic [1:0] LSL = 2'd0;
  localparam logic [1:0] LSR = 2'd1;
  localparam logic [1:0] ASR = 2'd2;
  localparam logic [1:0] ROL = 2'd3;

  typedef struct {
    logic [63:0] data;
    logic [1:0]  mode;
    int          acc_cyc;
    int          acc_stall;
  } entry_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid  [2];
  logic [63:0] in_data   [2];
  logic [5:0]  in_shamt  [2];
  logic [1:0]  in_mode   [2];
  logic        out_ready [2];
  logic        in_ready  [2];
  logic        out_valid [2];
  logic [63:0] out_data  [2];
  logic [1:0]  out_mode  [2];
  logic        out_zero  [2];
  logic [15:0] out_data_16;
  logic [31:0] out_data_32;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  entry_t sb [2][$];
  int     stall_cnt  [2] = '{0, 0};
  bit     stall_prev [2] = '{0, 0};
  bit     rst_seen   [2] = '{0, 0};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pipelined_barrel_shifter #(.WIDTH(16)) dut16 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid[0]),
    .in_ready  (in_ready[0]),
    .in_data   (in_data[0][15:0]),
    .in_shamt  (in_shamt[0][3:0]),
    .in_mode   (in_mode[0]),
    .out_valid (out_valid[0]),
    .out_ready (out_ready[0]),
    .out_data  (out_data_16),
    .out_mode  (out_mode[0]),
    .out_zero  (out_zero[0])
  );

  pipelined_barrel_shifter #(.WIDTH(32)) dut32 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid[1]),
    .in_ready  (in_ready[1]),
    .in_data   (in_data[1][31:0]),
    .in_shamt  (in_shamt[1][4:0]),
    .in_mode   (in_mode[1]),
    .out_valid (out_valid[1]),
    .out_ready (out_ready[1]),
    .out_data  (out_data_32),
    .out_mode  (out_mode[1]),
    .out_zero  (out_zero[1])
  );

  assign out_data[0] = {48'd0, out_data_16};
  assign out_data[1] = {32'd0, out_data_32};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: shift rules written as plain arithmetic on a w-bit value.
  function automatic logic [63:0] model(input int w, input logic [63:0] d_in,
                                        input int s, input logic [1:0] m);
    logic [63:0] mask;
    logic [63:0] d;
    logic [63:0] r;
    mask = (64'd1 << w) - 64'd1;
    d    = d_in & mask;
    case (m)
      LSL:     r = (d << s) & mask;
      LSR:     r = d >> s;
      ASR: begin
        r = d >> s;
        if (d[w-1]) r = r | (mask & ~(mask >> s));
      end
      default: r = ((d << s) | (d >> (w - s))) & mask;
    endcase
    return r;
  endfunction

  // Compare process: every falling edge, for both instances.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int     w;
      int     shw;
      entry_t e;
      w   = (i == 0) ? 16 : 32;
      shw = (i == 0) ? 4 : 5;
      if (reset) begin
        sb[i].delete();
        stall_prev[i] = 1'b0;
        rst_seen[i]   = 1'b1;
      end else begin
        if (rst_seen[i]) begin
          check("reset out_valid", 64'(out_valid[i]), 64'd0);
          check("reset out_data",  out_data[i],       64'd0);
          check("reset out_mode",  64'(out_mode[i]),  64'd0);
          check("reset out_zero",  64'(out_zero[i]),  64'd0);
          check("reset in_ready",  64'(in_ready[i]),  64'd1);
          rst_seen[i] = 1'b0;
        end
        if (stall_prev[i]) check("held out_valid", 64'(out_valid[i]), 64'd1);
        if (out_valid[i]) begin
          if (sb[i].size() == 0) begin
            check("unexpected result", 64'(out_valid[i]), 64'd0);
          end else begin
            e = sb[i][0];
            check("sb data", out_data[i], e.data);
            check("sb mode", 64'(out_mode[i]), 64'(e.mode));
            check("sb zero", 64'(out_zero[i]), 64'(e.data == 64'd0));
            if (out_ready[i]) begin
              if (stall_cnt[i] == e.acc_stall)
                check("sb latency", 64'(cyc - e.acc_cyc), 64'(shw));
              void'(sb[i].pop_front());
            end
          end
          stall_prev[i] = !out_ready[i];
          if (!out_ready[i]) stall_cnt[i]++;
        end else begin
          stall_prev[i] = 1'b0;
        end
        if (in_valid[i] && in_ready[i]) begin
          e.data      = model(w, in_data[i], int'(in_shamt[i]) % w, in_mode[i]);
          e.mode      = in_mode[i];
          e.acc_cyc   = cyc;
          e.acc_stall = stall_cnt[i];
          sb[i].push_back(e);
        end
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Present one operation (caller is just after a rising edge); returns after it is accepted.
  task automatic issue(input int i, input logic [63:0] d, input int s, input logic [1:0] m,
                       output int waits);
    int n;
    n = 0;
    in_valid[i] = 1'b1;
    in_data[i]  = d;
    in_shamt[i] = 6'(s);
    in_mode[i]  = m;
    @(negedge clk);
    while (!in_ready[i] && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (n == 100) check("issue timeout", 64'd0, 64'd1);
    waits = n;
    @(posedge clk);
    #1;
    in_valid[i] = 1'b0;
  endtask

  // Wait (bounded) for the next result and compare it with a literal.
  task automatic wait_out(input int i, input logic [63:0] exp, input logic ez,
                          input int lat, input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid[i] && n < 50);
    check({name, " valid"}, 64'(out_valid[i]), 64'd1);
    check({name, " data"},  out_data[i], exp);
    check({name, " zero"},  64'(out_zero[i]), 64'(ez));
    if (lat > 0) check({name, " latency"}, 64'(n), 64'(lat));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not complete (t=%0t)", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid[i]  = 1'b0;
      in_data[i]   = '0;
      in_shamt[i]  = '0;
      in_mode[i]   = '0;
      out_ready[i] = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    sync();

    // Single op, latency and value.
    issue(0, 64'h0001, 15, LSL, w);
    wait_out(0, 64'h8000, 1'b0, 4, "lsl 1 by 15");
    sync();

    // Mode checks.
    issue(0, 64'h8000, 4, ASR, w);
    wait_out(0, 64'hF800, 1'b0, 4, "asr 8000 by 4");
    sync();
    issue(0, 64'h8000, 4, LSR, w);
    wait_out(0, 64'h0800, 1'b0, 4, "lsr 8000 by 4");
    sync();
    issue(0, 64'h8000, 4, LSL, w);
    wait_out(0, 64'h0000, 1'b1, 4, "lsl 8000 by 4");
    sync();
    issue(0, 64'h8001, 1, ROL, w);
    wait_out(0, 64'h0003, 1'b0, 4, "rol 8001 by 1");
    sync();
    issue(0, 64'h1234, 0, ASR, w);
    wait_out(0, 64'h1234, 1'b0, 4, "asr by 0");
    sync();

    // Back-to-back sweep: LSR 0xFFFF by 0..15 on consecutive cycles.
    fork
      begin
        for (int s = 0; s < 16; s++) begin
          int ws;
          issue(0, 64'hFFFF, s, LSR, ws);
          check("sweep in_ready", 64'(ws), 64'd0);
        end
      end
      begin
        int n;
        n = 0;
        while (!out_valid[0] && n < 50) begin
          @(negedge clk);
          n++;
        end
        for (int k = 0; k < 16; k++) begin
          check("sweep valid", 64'(out_valid[0]), 64'd1);
          check("sweep data", out_data[0], 64'hFFFF >> k);
          @(negedge clk);
        end
      end
    join
    sync();

    // Back-pressure: six ROL ops, consumer holds off for three cycles.
    out_ready[0] = 1'b0;
    fork
      begin
        for (int k = 1; k <= 6; k++) begin
          int ws;
          issue(0, 64'h8001, k, ROL, ws);
        end
      end
      begin
        int n;
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!out_valid[0] && n < 50);
        for (int h = 0; h < 3; h++) begin
          check("hold in_ready", 64'(in_ready[0]), 64'd0);
          check("hold data", out_data[0], 64'h0003);
          if (h < 2) @(negedge clk);
        end
        @(posedge clk);
        #1;
        out_ready[0] = 1'b1;
      end
    join
    repeat (12) sync();

    // Reset with three operations in flight.
    issue(0, 64'h00FF, 1, LSL, w);
    issue(0, 64'h00FF, 2, LSL, w);
    issue(0, 64'h00FF, 3, LSL, w);
    reset = 1'b1;
    sync();
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("no stale after reset", 64'(out_valid[0]), 64'd0);
    end
    sync();
    issue(0, 64'h0F0F, 4, LSL, w);
    wait_out(0, 64'hF0F0, 1'b0, 4, "after reset");
    sync();

    // 32-bit instance.
    issue(1, 64'h8000_0000, 31, ASR, w);
    wait_out(1, 64'hFFFF_FFFF, 1'b0, 5, "w32 asr by 31");
    sync();
    issue(1, 64'h0000_0001, 31, ROL, w);
    wait_out(1, 64'h8000_0000, 1'b0, 5, "w32 rol by 31");
    sync();

    repeat (10) sync();
    check("drain w16", 64'(sb[0].size()), 64'd0);
    check("drain w32", 64'(sb[1].size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
